apb_cmd_master: RTL and testbench

Single-outstanding AMBA APB3/APB4 requester that turns a valid/ready command stream into APB transfers and returns one response per command. It is the initiator end of the APB links in the AHB-to-APB design and the traffic source in APB-slave benches. It supports back-to-back transfers, wait states via `PREADY`, `PSLVERR` passthrough and an optional wait-state watchdog.

---
 rtl/apb_cmd_master.sv | 141 ++++++++++++++
 tb/tb_apb_cmd_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB3/APB4 requester: converts a valid/ready command stream
// into APB transfers and returns one registered response pulse per command.
module apb_cmd_master #(
    parameter int ADDRWIDTH   = 32,
    parameter int P_TIMEOUT   = 0,
    parameter int P_BACK2BACK = 1
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    // command stream
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDRWIDTH-1:0] cmd_addr,
    input  logic [31:0]          cmd_wdata,
    input  logic [3:0]           cmd_strb,
    input  logic [2:0]           cmd_prot,
    // response stream
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic                 busy,
    // APB requester
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic                 PREADY,
    input  logic                 PSLVERR,
    input  logic [31:0]          PRDATA
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST  = (P_TIMEOUT == 0) ? 8'd0 : 8'(P_TIMEOUT - 1);
    localparam logic       WDOG_EN  = (P_TIMEOUT != 0);
    localparam logic       B2B_EN   = (P_BACK2BACK != 0);

    state_t                state_q;
    logic [7:0]            wcnt_q;
    logic                  pwrite_q;
    logic [ADDRWIDTH-1:0]  paddr_q;
    logic [31:0]           pwdata_q;
    logic [3:0]            pstrb_q;
    logic [2:0]            pprot_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [31:0]           rsp_rdata_q;

    logic                  timeout_hit;
    logic                  done;
    logic                  accept;
    logic [31:0]           pwdata_d;
    logic [3:0]            pstrb_d;
    logic                  rsp_err_d;
    logic [31:0]           rsp_rdata_d;

    // wcnt_q counts PREADY-low ACCESS cycles already spent on this transfer
    assign timeout_hit = WDOG_EN && !PREADY && (wcnt_q == TO_LAST);
    assign done        = PREADY || timeout_hit;

    // Gated by PRESETn so the handshake is dead while reset is asserted
    assign cmd_ready = PRESETn &&
                       ((state_q == S_IDLE) || (B2B_EN && (state_q == S_ACCESS) && done));
    assign accept    = cmd_valid && cmd_ready;

    // Reads never drive write data or strobes onto the bus
    assign pwdata_d    = cmd_write ? cmd_wdata : 32'd0;
    assign pstrb_d     = cmd_write ? cmd_strb  : 4'd0;
    assign rsp_err_d   = (PSLVERR && PREADY) || timeout_hit;
    assign rsp_rdata_d = (!pwrite_q && PREADY && !PSLVERR) ? PRDATA : 32'd0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= S_IDLE;
            wcnt_q      <= 8'd0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= 32'd0;
            pstrb_q     <= 4'd0;
            pprot_q     <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;

            case (state_q)
                S_IDLE: begin
                    if (accept) state_q <= S_SETUP;
                end
                S_SETUP: begin
                    state_q <= S_ACCESS;
                    wcnt_q  <= 8'd0;
                end
                S_ACCESS: begin
                    if (done) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= rsp_err_d;
                        rsp_rdata_q <= rsp_rdata_d;
                        state_q     <= accept ? S_SETUP : S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // Bus fields only change on accept, so they hold through ACCESS and IDLE
            if (accept) begin
                pwrite_q <= cmd_write;
                paddr_q  <= cmd_addr;
                pwdata_q <= pwdata_d;
                pstrb_q  <= pstrb_d;
                pprot_q  <= cmd_prot;
            end
        end
    end

    assign PSEL      = (state_q != S_IDLE);
    assign PENABLE   = (state_q == S_ACCESS);
    assign busy      = (state_q != S_IDLE);
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master: a memory-backed APB slave with per-command
// wait/error plans, a spec-level reference model, and a decoupled response monitor.
module tb_apb_cmd_master;
    localparam int AW = 32;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [31:0]   cmd_wdata = '0;
    logic [3:0]    cmd_strb = '0;
    logic [2:0]    cmd_prot = '0;
    logic          rsp_valid, rsp_err, busy;
    logic [31:0]   rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic          PREADY = 1'b0, PSLVERR = 1'b0;
    logic [31:0]   PRDATA = '0;

    apb_cmd_master #(.ADDRWIDTH(AW), .P_TIMEOUT(TO), .P_BACK2BACK(1)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    // w<0 means the slave never raises PREADY
    typedef struct { int w; bit err; } plan_t;
    typedef struct { logic [31:0] rdata; bit err; int cyc; } exp_t;

    plan_t       plan_q[$];
    exp_t        exp_q[$];
    logic [31:0] ref_mem [64];
    logic [31:0] slv_mem [64];
    int          cyc = 0, n_chk = 0, n_pass = 0, rsp_cnt = 0;

    always @(posedge PCLK) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail(input string name);
        n_chk++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- APB slave ----------------
    plan_t cur;
    int    acc_n;
    bit    rdy;
    always begin
        @(posedge PCLK); #1;
        if (PSEL && !PENABLE) begin
            if (plan_q.size() > 0) cur = plan_q.pop_front();
            else begin fail("plan_missing"); cur.w = 0; cur.err = 1'b0; end
            acc_n   = 0;
            PREADY  = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
        end else if (PSEL && PENABLE) begin
            rdy     = (cur.w >= 0) && (acc_n == cur.w);
            acc_n++;
            PREADY  = rdy;
            PSLVERR = rdy ? cur.err : 1'($urandom);
            PRDATA  = $urandom;
            if (rdy && !cur.err) begin
                if (PWRITE) begin
                    for (int b = 0; b < 4; b++)
                        if (PSTRB[b]) slv_mem[PADDR[7:2]][8*b +: 8] = PWDATA[8*b +: 8];
                end else PRDATA = slv_mem[PADDR[7:2]];
            end
            if (rdy && cur.err && !PWRITE) PRDATA = 32'hDEAD_BEEF;
        end else begin
            PREADY  = 1'($urandom);
            PSLVERR = 1'($urandom);
            PRDATA  = $urandom;
        end
    end

    // ---------------- monitor ----------------
    logic [71:0] prev_bus = '0;
    logic        prev_psel = 1'b0, prev_rv = 1'b0;
    exp_t        e;
    always @(negedge PCLK) begin
        if (!PRESETn) begin
            chk("rst_psel", PSEL, 0);
            chk("rst_penable", PENABLE, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_cmd_ready", cmd_ready, 0);
        end else begin
            if (rsp_valid) begin
                rsp_cnt++;
                chk("rsp_back_to_back", prev_rv, 0);
                if (exp_q.size() == 0) fail("rsp_unexpected");
                else begin
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", rsp_err, e.err);
                    chk("rsp_cycle", cyc, e.cyc);
                end
            end
            if (PSEL && PENABLE && prev_psel)
                chk("bus_stable", {PADDR, PWRITE, PPROT, PWDATA, PSTRB}, prev_bus);
            if (PSEL && !PENABLE && !PWRITE)
                chk("read_strb_wdata_zero", {PSTRB, PWDATA}, 0);
        end
        prev_bus  = {PADDR, PWRITE, PPROT, PWDATA, PSTRB};
        prev_psel = PSEL;
        prev_rv   = rsp_valid;
    end

    // ---------------- driver + reference model ----------------
    task automatic issue(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [2:0] prot, input int w, input bit err);
        bit   acc = 1'b0;
        exp_t x;
        int   idx;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr;
        cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
        for (int k = 0; k < 64 && !acc; k++) begin
            @(negedge PCLK);
            if (cmd_ready) begin
                acc = 1'b1;
                plan_q.push_back('{w, err});
                idx   = int'(addr[7:2]);
                x.cyc = cyc + 3 + ((w < 0) ? TO - 1 : w);
                x.rdata = 32'd0;
                x.err   = 1'b0;
                if (w < 0 || err) x.err = 1'b1;
                else if (wr) begin
                    for (int b = 0; b < 4; b++)
                        if (strb[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end else x.rdata = ref_mem[idx];
                exp_q.push_back(x);
            end
            @(posedge PCLK); #1;
        end
        if (!acc) fail("accept_timeout");
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        repeat (n) begin @(posedge PCLK); #1; end
    endtask

    int rc;
    initial begin
        for (int i = 0; i < 64; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
        repeat (3) @(posedge PCLK);
        #2 PRESETn = 1'b1;
        @(negedge PCLK);
        chk("ready_after_reset", cmd_ready, 1);
        @(posedge PCLK); #1;

        // zero-wait write then read
        issue(1, 32'h10, 32'hA5A5_1234, 4'hF, 3'd0, 0, 0); idle(4);
        issue(0, 32'h10, 32'h0, 4'hF, 3'd0, 0, 0);         idle(4);

        // strobed write merge
        issue(1, 32'h20, 32'hFFFF_FFFF, 4'hF, 3'd1, 0, 0); idle(4);
        issue(1, 32'h20, 32'h0000_0000, 4'h5, 3'd1, 0, 0); idle(4);
        issue(0, 32'h20, 32'h1234_5678, 4'hF, 3'd1, 0, 0); idle(4);
        chk("strobe_model", ref_mem[8], 32'hFF00_FF00);

        // three wait states
        issue(0, 32'h10, 32'h0, 4'h0, 3'd5, 3, 0); idle(8);

        // back-to-back stream: PSEL solid for 16 cycles, PENABLE alternating
        fork
            begin
                for (int i = 0; i < 8; i++)
                    issue(1, 32'h40 + 4 * i, 32'h1000 + i, 4'hF, 3'd2, 0, 0);
                idle(6);
            end
            begin
                bit seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge PCLK);
                    seen = PSEL;
                end
                if (!seen) fail("b2b_no_psel");
                else for (int j = 0; j < 16; j++) begin
                    chk("b2b_psel", PSEL, 1);
                    chk("b2b_penable", PENABLE, j % 2);
                    if (j < 15) @(negedge PCLK);
                end
            end
        join

        // stuck slave hits the watchdog, then slave error with junk data
        issue(0, 32'h10, 32'h0, 4'h0, 3'd0, -1, 0); idle(10);
        issue(0, 32'h10, 32'h0, 4'h0, 3'd0, 0, 1);  idle(4);

        // reset during an ACCESS wait state
        issue(0, 32'h10, 32'h0, 4'h0, 3'd0, 3, 0);
        idle(0);
        cmd_valid = 1'b0;
        begin
            bit inacc = 1'b0;
            for (int k = 0; k < 10 && !inacc; k++) begin
                @(negedge PCLK);
                inacc = PSEL && PENABLE;
            end
            if (!inacc) fail("reset_no_access");
        end
        @(posedge PCLK); #2;
        PRESETn = 1'b0;
        exp_q.delete();
        plan_q.delete();
        repeat (2) @(posedge PCLK);
        #2 PRESETn = 1'b1;
        rc = rsp_cnt;
        repeat (6) @(posedge PCLK);
        chk("no_rsp_after_reset", rsp_cnt, rc);
        #1;
        issue(0, 32'h10, 32'h0, 4'h0, 3'd0, 1, 0); idle(6);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            int r, g;
            r = $urandom_range(0, 9);
            issue(1'($urandom), {24'd0, 6'($urandom_range(0, 63)), 2'b00}, $urandom,
                  4'($urandom), 3'($urandom), (r == 0) ? -1 : $urandom_range(0, 3), r == 1);
            g = $urandom_range(0, 2);
            if (g > 0) idle(g);
        end
        idle(1);

        for (int k = 0; k < 200 && exp_q.size() > 0; k++) @(negedge PCLK);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("plans_consumed", plan_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
